// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// wb_req_t carries one pending register-file write: ALU input, holding buffer and rf_* register.
package writeback_arbiter_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;
endpackage

// File: rtl/writeback_arbiter_scoreboard.sv
// Per-register busy tracking for long-latency destinations, plus hazard-violation detection.
// Register x0 is never marked busy and never reported as a violation.
module wb_scoreboard
  import writeback_arbiter_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic                  alu_chk_en,
  input  logic [REG_ADDR_W-1:0] alu_chk_rd,
  input  logic                  lsu_chk_en,
  input  logic [REG_ADDR_W-1:0] lsu_chk_rd,
  output logic [REG_COUNT-1:0]  busy_mask,
  output logic                  err_pulse
);
  logic [REG_COUNT-1:0] r_busy;
  logic [REG_COUNT-1:0] w_set_vec;
  logic [REG_COUNT-1:0] w_clr_vec;
  logic                 w_waw;
  logic                 w_alu_raw;
  logic                 w_lsu_orphan;

  assign w_set_vec = REG_COUNT'(set_en & (|set_rd)) << set_rd;
  assign w_clr_vec = REG_COUNT'(clr_en) << clr_rd;

  assign w_waw        = set_en & (|set_rd) & r_busy[set_rd];
  assign w_alu_raw    = alu_chk_en & (|alu_chk_rd) & r_busy[alu_chk_rd];
  assign w_lsu_orphan = lsu_chk_en & (|lsu_chk_rd) & ~r_busy[lsu_chk_rd];
  assign err_pulse    = w_waw | w_alu_raw | w_lsu_orphan;

  // Set is applied after clear so a same-cycle mark on the retiring register keeps it busy.
  always_ff @(posedge clock) begin
    if (reset) r_busy <= '0;
    else       r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
  end

  assign busy_mask = r_busy;
endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the single register-file write port between the ALU and a long-latency unit,
// with a one-entry holding buffer and a starvation guard that briefly stalls the ALU.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_stall,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0]     lsu_data,
  input  logic                  mark_valid,
  input  logic [REG_ADDR_W-1:0] mark_rd,
  output logic [REG_COUNT-1:0]  busy_mask,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  protocol_error
);
  wb_req_t          r_buf;
  wb_req_t          r_rf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_perr;

  wb_req_t w_alu_req;
  logic    w_stall;
  logic    w_alu_sel;
  logic    w_buf_sel;
  logic    w_hs;
  logic    w_err;

  assign w_alu_req = {alu_valid, alu_rd, alu_data};
  assign w_stall   = (r_cnt == CNT_W'(STARVE_LIMIT));
  assign w_alu_sel = w_alu_req.valid & ~w_stall;
  assign w_buf_sel = ~w_alu_sel & r_buf.valid;
  assign w_hs      = lsu_valid & ~r_buf.valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_buf  <= '0;
      r_rf   <= '0;
      r_cnt  <= '0;
      r_perr <= 1'b0;
    end else begin
      // An x0 write still takes its slot; only the enable is suppressed.
      if (w_alu_sel)
        r_rf <= {(|w_alu_req.rd), w_alu_req.rd, w_alu_req.data};
      else if (w_buf_sel)
        r_rf <= {(|r_buf.rd), r_buf.rd, r_buf.data};
      else
        r_rf.valid <= 1'b0;

      // Push needs an empty buffer and pop needs a full one, so they never collide.
      if (w_buf_sel)
        r_buf.valid <= 1'b0;
      else if (w_hs)
        r_buf <= {1'b1, lsu_rd, lsu_data};

      if (r_buf.valid && w_alu_sel) r_cnt <= r_cnt + CNT_W'(1);
      else                          r_cnt <= '0;

      r_perr <= r_perr | w_err;
    end
  end

  wb_scoreboard u_sb (
    .clock      (clock),
    .reset      (reset),
    .set_en     (mark_valid),
    .set_rd     (mark_rd),
    .clr_en     (w_buf_sel),
    .clr_rd     (r_buf.rd),
    .alu_chk_en (w_alu_sel),
    .alu_chk_rd (w_alu_req.rd),
    .lsu_chk_en (w_hs),
    .lsu_chk_rd (lsu_rd),
    .busy_mask  (busy_mask),
    .err_pulse  (w_err)
  );

  assign alu_stall      = w_stall;
  assign lsu_ready      = ~r_buf.valid;
  assign rf_we          = r_rf.valid;
  assign rf_waddr       = r_rf.rd;
  assign rf_wdata       = r_rf.data;
  assign protocol_error = r_perr;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: expected register-file writes are queued when
// stimulus is driven and compared whenever the DUT asserts rf_we.
module tb_writeback_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        mark_valid;
  logic [4:0]  mark_rd;
  logic [31:0] busy_mask;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        protocol_error;

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] exp_q[$];

  always #5 clock = ~clock;

  writeback_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mark_valid(mark_valid), .mark_rd(mark_rd), .busy_mask(busy_mask),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .protocol_error(protocol_error)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset && rf_we) begin
      if (exp_q.size() == 0) begin
        chk("rf_unexpected_write", {27'd0, rf_waddr, rf_wdata}, 64'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("rf_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, e});
      end
    end
  end

  initial begin
    reset = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0; mark_valid = 0; mark_rd = 0;
    tick(); tick();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_ready", lsu_ready, 1);
    chk("rst_stall", alu_stall, 0);
    chk("rst_perr", protocol_error, 0);
    reset = 1'b0;
    tick();

    // ALU single write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    alu_valid = 0;
    chk("alu_we", rf_we, 1);
    chk("alu_busy", busy_mask, 0);
    tick();

    // Long-latency write to a marked register
    mark_valid = 1; mark_rd = 7;
    tick();
    mark_valid = 0;
    chk("mark7_busy", busy_mask[7], 1);
    tick(); tick();
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
    exp_q.push_back({5'd7, 32'h1234});
    chk("hs_ready", lsu_ready, 1);
    tick();
    lsu_valid = 0;
    chk("buf_ready_low", lsu_ready, 0);
    chk("lsu_no_bypass", rf_we, 0);
    chk("busy7_held", busy_mask[7], 1);
    tick();
    chk("lsu_we", rf_we, 1);
    chk("lsu_addr", rf_waddr, 7);
    chk("busy7_clear", busy_mask[7], 0);
    chk("ready_back", lsu_ready, 1);
    tick();

    // Starvation: buffered rd 9 against continuous ALU traffic
    mark_valid = 1; mark_rd = 9;
    tick();
    mark_valid = 0;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    tick();
    lsu_valid = 0;
    alu_valid = 1; alu_rd = 3;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'h300 + i;
      chk("starve_no_stall", alu_stall, 0);
      exp_q.push_back({5'd3, 32'h300 + i});
      tick();
    end
    alu_data = 32'h304;
    chk("starve_stall", alu_stall, 1);
    exp_q.push_back({5'd9, 32'h99});
    tick();
    chk("stall_one_cycle", alu_stall, 0);
    chk("busy9_clear", busy_mask[9], 0);
    exp_q.push_back({5'd3, 32'h304});
    tick();
    alu_valid = 0;
    chk("starve_ready", lsu_ready, 1);
    tick();

    // x0 writes consume slots but never enable
    mark_valid = 1; mark_rd = 0;
    tick();
    mark_valid = 0;
    alu_valid = 1; alu_rd = 0; alu_data = 32'hAA;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hBB;
    tick();
    alu_valid = 0; lsu_valid = 0;
    chk("x0_alu_we", rf_we, 0);
    chk("x0_buf_full", lsu_ready, 0);
    tick();
    chk("x0_buf_we", rf_we, 0);
    chk("x0_drained", lsu_ready, 1);
    chk("x0_busy", busy_mask, 0);
    chk("x0_perr", protocol_error, 0);

    // WAW on long op, sticky error, offending ALU write still lands
    mark_valid = 1; mark_rd = 4;
    tick();
    chk("waw_pre_perr", protocol_error, 0);
    tick();
    mark_valid = 0;
    chk("waw_perr", protocol_error, 1);
    chk("busy4", busy_mask[4], 1);
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    exp_q.push_back({5'd4, 32'h44});
    tick();
    alu_valid = 0;
    chk("raw_alu_we", rf_we, 1);
    chk("raw_alu_addr", rf_waddr, 4);
    tick();
    chk("perr_sticky", protocol_error, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("perr_rst", protocol_error, 0);
    chk("busy_rst", busy_mask, 0);

    // Reset discards a buffered result
    mark_valid = 1; mark_rd = 12;
    tick();
    mark_valid = 0;
    lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hC;
    tick();
    lsu_valid = 0;
    chk("buf_loaded", lsu_ready, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("rst2_ready", lsu_ready, 1);
    chk("rst2_busy", busy_mask, 0);
    chk("rst2_we", rf_we, 0);
    chk("rst2_perr", protocol_error, 0);
    tick(); tick();
    chk("rst2_no_write", rf_we, 0);
    tick();

    chk("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
